// File: rtl/uart_tx.sv
// uart_tx: serialises one DATA_BITS word as start, data (LSB first), optional parity, stop bit(s).
// Latency: tx_busy rises one cycle after an accepted tx_start; the start bit begins the cycle after the first baud_tick.
// Backpressure: tx_start is honoured only while tx_busy=0; requests made while busy are dropped, not queued.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // Counter is wide enough to hold DATA_BITS itself, so every legal width fits.
  localparam int                CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic              PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q,    state_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q,   parity_d;
  logic                 tx_q,       tx_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;

  // Next-state and next-output logic; every transition past SYNC waits for a baud_tick,
  // so bit length is set purely by the tick spacing.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A tick arriving together with tx_start is not used to begin the frame;
        // SYNC waits for the next one so the start bit is a full period long.
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          shift_d    = tx_data;
          parity_d   = (^tx_data) ^ PAR_INV;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = SYNC;
        end
      end

      SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (baud_tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end

      DATA: begin
        // bit_cnt_q is the index of the data bit currently on the line.
        if (baud_tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end

      STOP: begin
        // The tick closing the last stop period ends the frame; a tx_start seen in
        // this same cycle is still in STOP and therefore ignored.
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
